// File: rtl/iccm_uart_loader_if.sv
// ICCM write-port bundle driven by the boot loader: single-cycle writes, no backpressure.
// The memory is assumed to always grant, so req mirrors we.
interface iccm_uart_loader_if #(
    parameter int AddrW = 12
) ();
    logic             req;
    logic             we;
    logic [AddrW-1:0] addr;
    logic [31:0]      wdata;

    modport master (output req, we, addr, wdata);
    modport slave  (input  req, we, addr, wdata);
endinterface

// File: rtl/iccm_uart_loader.sv
// UART (8N1) boot loader: assembles LE words into ICCM, holds core in reset until EndWord.
// Latency: write issued 1 cycle after the 4th byte's stop sample; no backpressure (grant assumed).
module iccm_uart_loader #(
    parameter int          ClksPerBit = 868,
    parameter int          AddrW      = 12,
    parameter logic [31:0] EndWord    = 32'h0000_0FFF
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               prog_en_i,
    input  logic               rx_i,
    iccm_uart_loader_if.master iccm,
    output logic               core_hold_o,
    output logic               prog_done_o,
    output logic               frame_err_o,
    output logic               overflow_o
);

    localparam int              CntW    = $clog2(ClksPerBit);
    localparam logic [CntW-1:0] HalfCnt = CntW'(ClksPerBit / 2 - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(ClksPerBit - 1);
    localparam logic [AddrW-1:0] TopAddr = '1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {LD_WAIT_EN, LD_LOAD, LD_DONE} ld_state_t;

    logic             rx_meta, rx_sync;
    rx_state_t        rx_state, rx_state_n;
    logic [CntW-1:0]  cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift, shift_n;
    logic             byte_valid, byte_valid_n;
    logic             frame_err, frame_err_n;
    logic             rx_run;

    ld_state_t        ld_state, ld_state_n;
    logic [1:0]       byte_idx, byte_idx_n;
    logic [31:0]      word, word_n, asm_word;
    logic [AddrW-1:0] ptr, ptr_n;
    logic             we, we_n;
    logic [AddrW-1:0] addr, addr_n;
    logic [31:0]      wdata, wdata_n;
    logic             overflow, overflow_n;

    // Both sync flops reset high so reset never looks like a start bit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
        end
    end

    assign rx_run = prog_en_i && (ld_state == LD_LOAD);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_state   <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_state   <= rx_state_n;
            cnt        <= cnt_n;
            bit_idx    <= bit_idx_n;
            shift      <= shift_n;
            byte_valid <= byte_valid_n;
            frame_err  <= frame_err_n;
        end
    end

    always_comb begin
        rx_state_n   = rx_state;
        cnt_n        = cnt;
        bit_idx_n    = bit_idx;
        shift_n      = shift;
        byte_valid_n = 1'b0;
        frame_err_n  = frame_err;
        if (!rx_run) begin
            rx_state_n = RX_IDLE;
            cnt_n      = '0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    cnt_n = '0;
                    if (!rx_sync) rx_state_n = RX_START;
                end
                RX_START: begin
                    if (cnt == HalfCnt) begin
                        cnt_n      = '0;
                        bit_idx_n  = '0;
                        rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FullCnt) begin
                        cnt_n   = '0;
                        shift_n = {rx_sync, shift[7:1]};
                        if (bit_idx == 3'd7) rx_state_n = RX_STOP;
                        else                 bit_idx_n  = bit_idx + 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == FullCnt) begin
                        cnt_n      = '0;
                        rx_state_n = RX_IDLE;
                        if (rx_sync) byte_valid_n = 1'b1;
                        else         frame_err_n  = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: rx_state_n = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ld_state <= LD_WAIT_EN;
            byte_idx <= '0;
            word     <= '0;
            ptr      <= '0;
            we       <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            overflow <= 1'b0;
        end else begin
            ld_state <= ld_state_n;
            byte_idx <= byte_idx_n;
            word     <= word_n;
            ptr      <= ptr_n;
            we       <= we_n;
            addr     <= addr_n;
            wdata    <= wdata_n;
            overflow <= overflow_n;
        end
    end

    always_comb begin
        ld_state_n = ld_state;
        byte_idx_n = byte_idx;
        word_n     = word;
        ptr_n      = ptr;
        we_n       = 1'b0;
        addr_n     = addr;
        wdata_n    = wdata;
        overflow_n = overflow;
        asm_word   = word;
        asm_word[8*byte_idx +: 8] = shift;
        case (ld_state)
            LD_WAIT_EN: begin
                if (prog_en_i) begin
                    ld_state_n = LD_LOAD;
                    byte_idx_n = '0;
                    word_n     = '0;
                    ptr_n      = '0;
                end
            end
            LD_LOAD: begin
                // Abort takes priority over a byte landing in the same cycle.
                if (!prog_en_i) begin
                    ld_state_n = LD_WAIT_EN;
                end else if (we && addr == TopAddr) begin
                    overflow_n = 1'b1;
                    ld_state_n = LD_DONE;
                end else if (byte_valid) begin
                    word_n     = asm_word;
                    byte_idx_n = byte_idx + 1'b1;
                    if (byte_idx == 2'd3) begin
                        if (asm_word == EndWord) begin
                            ld_state_n = LD_DONE;
                        end else begin
                            we_n    = 1'b1;
                            addr_n  = ptr;
                            wdata_n = asm_word;
                            ptr_n   = ptr + 1'b1;
                        end
                    end
                end
            end
            default: ld_state_n = LD_DONE;
        endcase
    end

    assign iccm.req    = we;
    assign iccm.we     = we;
    assign iccm.addr   = addr;
    assign iccm.wdata  = wdata;
    assign core_hold_o = (ld_state != LD_DONE);
    assign prog_done_o = (ld_state == LD_DONE);
    assign frame_err_o = frame_err;
    assign overflow_o  = overflow;

endmodule

// File: tb/tb_iccm_uart_loader.sv
// Scoreboarded bench for iccm_uart_loader: stimulus pushes expected writes, a monitor pops them.
module tb_iccm_uart_loader;
    localparam int CPB = 8;
    localparam int AW  = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic clk = 1'b0;
    logic rst, prog_en, rx;
    logic core_hold, prog_done, frame_err, overflow;
    int   n_cmp = 0;
    int   n_err = 0;
    int   we_cnt = 0;
    int   base;
    wr_t  exp_q[$];

    iccm_uart_loader_if #(.AddrW(AW)) iccm ();

    iccm_uart_loader #(.ClksPerBit(CPB), .AddrW(AW), .EndWord(32'h0000_0FFF)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .prog_en_i  (prog_en),
        .rx_i       (rx),
        .iccm       (iccm),
        .core_hold_o(core_hold),
        .prog_done_o(prog_done),
        .frame_err_o(frame_err),
        .overflow_o (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && iccm.we) begin
            wr_t e;
            we_cnt++;
            check("req_with_we", {31'd0, iccm.req}, 32'd1);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write", iccm.addr, iccm.wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", {28'd0, iccm.addr}, {28'd0, e.addr});
                check("wr_data", iccm.wdata, e.data);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = stop_ok;
        tick(CPB);
        rx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w, input logic [AW-1:0] a, input logic expect_wr);
        if (expect_wr) exp_q.push_back('{addr: a, data: w});
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req"},   {31'd0, iccm.req}, 32'd0);
        check({tag, "_we"},    {31'd0, iccm.we}, 32'd0);
        check({tag, "_addr"},  {28'd0, iccm.addr}, 32'd0);
        check({tag, "_wdata"}, iccm.wdata, 32'd0);
        check({tag, "_hold"},  {31'd0, core_hold}, 32'd1);
        check({tag, "_done"},  {31'd0, prog_done}, 32'd0);
        check({tag, "_ferr"},  {31'd0, frame_err}, 32'd0);
        check({tag, "_ovf"},   {31'd0, overflow}, 32'd0);
    endtask

    task automatic start_scenario();
        prog_en = 1'b0;
        rx      = 1'b1;
        rst     = 1'b1;
        tick(2);
        rst     = 1'b0;
        prog_en = 1'b1;
        tick(3);
        base = we_cnt;
    endtask

    initial begin
        rst = 1'b1;
        prog_en = 1'b0;
        rx = 1'b1;
        tick(3);
        check_reset_vals("rst");

        // Single word followed by the end marker.
        start_scenario();
        send_word(32'h1234_5678, 4'd0, 1'b1);
        send_word(32'h0000_0FFF, 4'd0, 1'b0);
        tick(4);
        check("s1_done", {31'd0, prog_done}, 32'd1);
        check("s1_hold", {31'd0, core_hold}, 32'd0);
        check("s1_we_count", we_cnt - base, 32'd1);
        check("s1_pending", exp_q.size(), 32'd0);

        // Three words, then end marker.
        start_scenario();
        send_word(32'hDEAD_BEEF, 4'd0, 1'b1);
        send_word(32'h0000_0001, 4'd1, 1'b1);
        send_word(32'hCAFE_F00D, 4'd2, 1'b1);
        send_word(32'h0000_0FFF, 4'd0, 1'b0);
        tick(4);
        check("s2_we_count", we_cnt - base, 32'd3);
        check("s2_done", {31'd0, prog_done}, 32'd1);
        check("s2_pending", exp_q.size(), 32'd0);

        // Framing error on AA, then a good word lands at address 0.
        start_scenario();
        send_byte(8'hAA, 1'b0);
        tick(20);
        check("s3_ferr", {31'd0, frame_err}, 32'd1);
        send_word(32'h1122_3344, 4'd0, 1'b1);
        tick(4);
        check("s3_ferr_sticky", {31'd0, frame_err}, 32'd1);
        check("s3_done", {31'd0, prog_done}, 32'd0);
        check("s3_pending", exp_q.size(), 32'd0);

        // Two-cycle glitch on the line is ignored.
        start_scenario();
        rx = 1'b0;
        tick(2);
        rx = 1'b1;
        tick(30);
        check("s4_ferr", {31'd0, frame_err}, 32'd0);
        check("s4_no_write", we_cnt - base, 32'd0);
        send_word(32'h0A0B_0C0D, 4'd0, 1'b1);
        tick(4);
        check("s4_pending", exp_q.size(), 32'd0);

        // Fill all 16 words without an end marker.
        start_scenario();
        for (int i = 0; i < 16; i++) send_word(32'hA000_0000 | i, AW'(i), 1'b1);
        tick(4);
        check("s5_ovf", {31'd0, overflow}, 32'd1);
        check("s5_done", {31'd0, prog_done}, 32'd1);
        check("s5_hold", {31'd0, core_hold}, 32'd0);
        check("s5_we_count", we_cnt - base, 32'd16);
        check("s5_pending", exp_q.size(), 32'd0);

        // Abort mid-word discards the partial bytes.
        start_scenario();
        send_byte(8'hEE, 1'b1);
        send_byte(8'hDD, 1'b1);
        prog_en = 1'b0;
        tick(3);
        check("s6_hold_abort", {31'd0, core_hold}, 32'd1);
        prog_en = 1'b1;
        tick(3);
        send_word(32'h5566_7788, 4'd0, 1'b1);
        tick(4);
        check("s6_done", {31'd0, prog_done}, 32'd0);
        check("s6_pending", exp_q.size(), 32'd0);

        // Reset mid-DATA after flags and write port have moved away from reset.
        start_scenario();
        send_byte(8'h3C, 1'b0);
        tick(20);
        send_word(32'h0BAD_F00D, 4'd0, 1'b1);
        send_word(32'h1212_1212, 4'd1, 1'b1);
        tick(4);
        check("s7_pre_addr", {28'd0, iccm.addr}, 32'd1);
        check("s7_pre_ferr", {31'd0, frame_err}, 32'd1);
        rx = 1'b0;
        tick(CPB * 3);
        rst = 1'b1;
        rx  = 1'b1;
        tick(1);
        check_reset_vals("s7");
        rst = 1'b0;
        tick(2);
        check("s7_pending", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
